ifu_fetch: RTL and testbench

Instruction fetch unit: owns the PC and the instruction-bus master port, and buffers fetched words for ID. It is the consumer of the pipeline controller's `jump_flag_o`/`jump_addr_o`/`hold_flag_o`. It answers with `fetch_stall_o`, which enters the controller on the same priority as the bus hold request (PC-level hold). The unit allows one outstanding bus transaction and holds fetched words in a 2-entry FIFO.

---
 rtl/ifu_fetch_pkg.sv | 38 +++
 rtl/ifu_fetch_fifo.sv | 77 +++++++
 rtl/ifu_fetch.sv | 149 ++++++++++++++
 tb/tb_ifu_fetch.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_fetch_pkg.sv
// ----------------------------------------------------------------------------
// ifu_fetch_pkg
// Shared definitions for the instruction fetch unit: controller hold levels,
// bus/word widths, the reset PC, the NOP encoding, the fetch FSM state type
// and the layout of one buffered fetch entry.
// ----------------------------------------------------------------------------
package ifu_fetch_pkg;

    localparam int          INST_ADDR_W    = 32;
    localparam int          INST_W         = 32;
    localparam int          HOLD_W         = 3;

    localparam logic [INST_ADDR_W-1:0] CPU_RESET_ADDR = 32'h0000_0000;
    localparam logic [INST_W-1:0]      INST_NOP       = 32'h0000_0013;

    // Controller hold levels, ordered so that a larger value holds more.
    localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // nothing outstanding on the bus
        ST_REQ  = 2'd1,   // request driven, waiting for grant
        ST_WAIT = 2'd2    // granted, waiting for read data
    } fetch_state_e;

    // One FIFO entry: address in the upper half, instruction word in the lower.
    typedef struct packed {
        logic [INST_ADDR_W-1:0] addr;
        logic [INST_W-1:0]      data;
    } fetch_entry_t;

    function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] a);
        return {a[INST_ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// ----------------------------------------------------------------------------
// ifu_fifo
// Two-deep, 64-bit synchronous FIFO holding {addr, inst} pairs.
// Entry 0 is always the head, so the head is read straight from a register.
// Push and pop may happen in the same cycle, including when full.
// Flush empties the FIFO and takes priority over push/pop.
//
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   flush_i        drop all entries
//   push_i         write push_data_i at the tail
//   push_data_i    {addr, inst}
//   pop_i          consume the head (ignored when empty)
//   count_o        number of valid entries (0..2)
//   head_o         head entry (meaningful when count_o != 0)
// ----------------------------------------------------------------------------
module ifu_fifo
    import ifu_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rstn,
    input  logic        flush_i,
    input  logic        push_i,
    input  logic [63:0] push_data_i,
    input  logic        pop_i,
    output logic [1:0]  count_o,
    output logic [63:0] head_o
);

    logic [63:0] ent0_q, ent0_d;
    logic [63:0] ent1_q, ent1_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [1:0]  cnt_after_pop;
    logic        do_pop, do_push;

    always_comb begin
        ent0_d        = ent0_q;
        ent1_d        = ent1_q;
        cnt_d         = cnt_q;
        do_pop        = pop_i && (cnt_q != 2'd0);
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        do_push       = push_i && ((cnt_q != 2'd2) || do_pop);
        cnt_after_pop = cnt_q - {1'b0, do_pop};

        if (flush_i) begin
            cnt_d = 2'd0;
        end else begin
            if (do_pop) begin
                ent0_d = ent1_q;
            end
            if (do_push) begin
                if (cnt_after_pop == 2'd0) begin
                    ent0_d = push_data_i;
                end else begin
                    ent1_d = push_data_i;
                end
            end
            cnt_d = cnt_after_pop + {1'b0, do_push};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ent0_q <= '0;
            ent1_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            ent0_q <= ent0_d;
            ent1_q <= ent1_d;
            cnt_q  <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = ent0_q;

endmodule

// File: rtl/ifu_fetch.sv
// ----------------------------------------------------------------------------
// ifu_fetch
// Instruction fetch unit. Owns the PC and the instruction-bus master port,
// keeps at most one bus transaction outstanding, and buffers returned words
// in a 2-entry FIFO that feeds ID.
//
// Ports:
//   clk, rstn        clock, asynchronous active-low reset
//   jump_flag_i      redirect from the pipeline controller (beats every hold)
//   jump_addr_i      redirect target, low two bits ignored
//   hold_flag_i      controller hold level (NONE/PC/IF/ID)
//   ibus_req_o       bus request, stable with its address until granted
//   ibus_addr_o      word-aligned fetch address
//   ibus_gnt_i       request accepted this cycle
//   ibus_rvalid_i    read data valid
//   ibus_rdata_i     read data
//   inst_o           FIFO head instruction, or NOP_INST when empty
//   inst_addr_o      FIFO head address, or 0 when empty
//   inst_valid_o     FIFO non-empty
//   fetch_stall_o    asks the controller for a PC-level hold while starved
// ----------------------------------------------------------------------------
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = CPU_RESET_ADDR,
    parameter logic [31:0] NOP_INST   = INST_NOP
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic [2:0]  hold_flag_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o,
    output logic        inst_valid_o,
    output logic        fetch_stall_o
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         discard_q, discard_d;

    logic [1:0]   fifo_cnt;
    logic [63:0]  fifo_head;
    fetch_entry_t push_entry, head_entry;
    logic         fifo_push, fifo_pop;
    logic         inst_valid;
    logic         can_issue;

    assign inst_valid = (fifo_cnt != 2'd0);

    // Issue is only evaluated in IDLE, where nothing is in flight, so the
    // "count + in-flight < 2" room check reduces to the FIFO count alone.
    assign can_issue = (hold_flag_i == HOLD_NONE) && (fifo_cnt != 2'd2) && !jump_flag_i;

    // ID consumes the head unless the hold level reaches IF, or a redirect is
    // flushing the FIFO this cycle.
    assign fifo_pop = inst_valid && (hold_flag_i < HOLD_IF) && !jump_flag_i;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        addr_d    = addr_q;
        discard_d = discard_q;
        fifo_push = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (can_issue) begin
                    state_d = ST_REQ;
                    addr_d  = pc_q;
                end
            end
            ST_REQ: begin
                // Request and address are frozen here until granted, whatever
                // the controller does.
                if (ibus_gnt_i) begin
                    state_d = ST_WAIT;
                    // A transaction that is going to be thrown away must not
                    // advance the PC past a redirect target not yet fetched.
                    if (!discard_q && !jump_flag_i) begin
                        pc_d = pc_q + 32'd4;
                    end
                end
            end
            ST_WAIT: begin
                if (ibus_rvalid_i) begin
                    state_d   = ST_IDLE;
                    fifo_push = !discard_q && !jump_flag_i;
                    discard_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (jump_flag_i) begin
            pc_d = word_align(jump_addr_i);
            // The outstanding transaction belongs to the old stream. When its
            // data returns in this very cycle it is dropped above and the
            // transaction is over, so nothing is left to mark.
            if ((state_q == ST_REQ) || ((state_q == ST_WAIT) && !ibus_rvalid_i)) begin
                discard_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            pc_q      <= RESET_ADDR;
            addr_q    <= RESET_ADDR;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            addr_q    <= addr_d;
            discard_q <= discard_d;
        end
    end

    assign push_entry = '{addr: addr_q, data: ibus_rdata_i};

    ifu_fifo u_fifo (
        .clk         (clk),
        .rstn        (rstn),
        .flush_i     (jump_flag_i),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .count_o     (fifo_cnt),
        .head_o      (fifo_head)
    );

    assign head_entry    = fetch_entry_t'(fifo_head);

    assign ibus_req_o    = (state_q == ST_REQ);
    assign ibus_addr_o   = addr_q;
    assign inst_valid_o  = inst_valid;
    assign inst_o        = inst_valid ? head_entry.data : NOP_INST;
    assign inst_addr_o   = inst_valid ? head_entry.addr : 32'h0;
    assign fetch_stall_o = !inst_valid && !jump_flag_i;

endmodule

// File: tb/tb_ifu_fetch.sv
module tb_ifu_fetch;
    import ifu_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        jump_flag_i;
    logic [31:0] jump_addr_i;
    logic [2:0]  hold_flag_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        fetch_stall_o;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    ifu_fetch dut (
        .clk           (clk),
        .rstn          (rstn),
        .jump_flag_i   (jump_flag_i),
        .jump_addr_i   (jump_addr_i),
        .hold_flag_i   (hold_flag_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .inst_o        (inst_o),
        .inst_addr_o   (inst_addr_o),
        .inst_valid_o  (inst_valid_o),
        .fetch_stall_o (fetch_stall_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic [2:0] h, input logic j, input logic [31:0] ja,
                       input logic g, input logic rv, input logic [31:0] rd);
        hold_flag_i   = h;
        jump_flag_i   = j;
        jump_addr_i   = ja;
        ibus_gnt_i    = g;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rd;
    endtask

    // Drive one cycle's inputs at the falling edge, settle, then let the caller check.
    task automatic step(input logic [2:0] h, input logic j, input logic [31:0] ja,
                        input logic g, input logic rv, input logic [31:0] rd);
        @(negedge clk);
        drv(h, j, ja, g, rv, rd);
        #1;
    endtask

    // Release lands between a rising and falling edge, so the next falling
    // edge still observes the reset state.
    task automatic reset_dut();
        rstn = 1'b0;
        drv(HOLD_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
    endtask

    typedef struct {
        logic [2:0]  hold;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_inst;
        logic [31:0] e_iaddr;
        logic        e_stall;
    } vec_t;

    vec_t tbl [11];

    task automatic run_table();
        tbl[0]  = '{3'd0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b0, NOP,           32'h0, 1'b1};
        tbl[1]  = '{3'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h0, 1'b0, NOP,           32'h0, 1'b1};
        tbl[2]  = '{3'd0, 1'b0, 1'b1, 32'hAAAA_0001, 1'b0, 32'h0, 1'b0, NOP,           32'h0, 1'b1};
        tbl[3]  = '{3'd0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h0, 1'b1, 32'hAAAA_0001, 32'h0, 1'b0};
        tbl[4]  = '{3'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h4, 1'b0, NOP,           32'h0, 1'b1};
        tbl[5]  = '{3'd3, 1'b0, 1'b1, 32'h1234_5678, 1'b0, 32'h4, 1'b0, NOP,           32'h0, 1'b1};
        tbl[6]  = '{3'd3, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4, 1'b1, 32'h1234_5678, 32'h4, 1'b0};
        tbl[7]  = '{3'd3, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4, 1'b1, 32'h1234_5678, 32'h4, 1'b0};
        tbl[8]  = '{3'd1, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4, 1'b1, 32'h1234_5678, 32'h4, 1'b0};
        tbl[9]  = '{3'd0, 1'b0, 1'b0, 32'h0,         1'b0, 32'h4, 1'b0, NOP,           32'h0, 1'b1};
        tbl[10] = '{3'd0, 1'b1, 1'b0, 32'h0,         1'b1, 32'h8, 1'b0, NOP,           32'h0, 1'b1};
        reset_dut();
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].hold, 1'b0, 32'h0, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
            chk($sformatf("tbl%0d_req", i),   ibus_req_o,    tbl[i].e_req);
            chk($sformatf("tbl%0d_addr", i),  ibus_addr_o,   tbl[i].e_addr);
            chk($sformatf("tbl%0d_valid", i), inst_valid_o,  tbl[i].e_valid);
            chk($sformatf("tbl%0d_inst", i),  inst_o,        tbl[i].e_inst);
            chk($sformatf("tbl%0d_iaddr", i), inst_addr_o,   tbl[i].e_iaddr);
            chk($sformatf("tbl%0d_stall", i), fetch_stall_o, tbl[i].e_stall);
        end
    endtask

    task automatic seq_jump_wait();
        reset_dut();
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        step(HOLD_NONE, 0, 0, 1, 0, 0);
        chk("jw_req", ibus_req_o, 1);
        step(HOLD_NONE, 1, 32'h0000_0103, 0, 0, 0);
        chk("jw_stall_jump", fetch_stall_o, 0);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("jw_valid_after_jump", inst_valid_o, 0);
        step(HOLD_NONE, 0, 0, 0, 1, 32'hDEAD_BEEF);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("jw_dropped", inst_valid_o, 0);
        chk("jw_req_idle", ibus_req_o, 0);
        step(HOLD_NONE, 0, 0, 1, 0, 0);
        chk("jw_req_tgt", ibus_req_o, 1);
        chk("jw_addr_tgt", ibus_addr_o, 32'h0000_0100);
        step(HOLD_NONE, 0, 0, 0, 1, 32'hBEEF_0100);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("jw_valid_tgt", inst_valid_o, 1);
        chk("jw_inst_tgt", inst_o, 32'hBEEF_0100);
        chk("jw_iaddr_tgt", inst_addr_o, 32'h0000_0100);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("jw_next_addr", ibus_addr_o, 32'h0000_0104);
    endtask

    task automatic seq_jump_req();
        reset_dut();
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        step(HOLD_ID, 1, 32'h0000_0200, 0, 0, 0);
        chk("jr_req", ibus_req_o, 1);
        for (int k = 0; k < 2; k++) begin
            step(HOLD_NONE, 0, 0, 0, 0, 0);
            chk($sformatf("jr_req_hold%0d", k), ibus_req_o, 1);
            chk($sformatf("jr_addr_hold%0d", k), ibus_addr_o, 32'h0);
        end
        step(HOLD_NONE, 0, 0, 1, 0, 0);
        chk("jr_addr_gnt", ibus_addr_o, 32'h0);
        step(HOLD_NONE, 0, 0, 0, 1, 32'h5555_5555);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("jr_dropped", inst_valid_o, 0);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("jr_req_tgt", ibus_req_o, 1);
        chk("jr_addr_tgt", ibus_addr_o, 32'h0000_0200);
    endtask

    task automatic seq_wrap();
        reset_dut();
        step(HOLD_NONE, 1, 32'hFFFF_FFFF, 0, 0, 0);
        chk("wr_stall_jump", fetch_stall_o, 0);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("wr_no_issue_on_jump", ibus_req_o, 0);
        step(HOLD_NONE, 0, 0, 1, 0, 0);
        chk("wr_addr_top", ibus_addr_o, 32'hFFFF_FFFC);
        step(HOLD_NONE, 0, 0, 0, 1, 32'h0000_0077);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("wr_inst", inst_o, 32'h0000_0077);
        chk("wr_iaddr", inst_addr_o, 32'hFFFF_FFFC);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("wr_req_wrap", ibus_req_o, 1);
        chk("wr_addr_wrap", ibus_addr_o, 32'h0);
    endtask

    task automatic seq_reset_mid();
        reset_dut();
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        step(HOLD_NONE, 0, 0, 1, 0, 0);
        step(HOLD_NONE, 0, 0, 0, 1, 32'h0000_0099);
        step(HOLD_IF, 0, 0, 0, 0, 0);
        chk("rm_valid_before", inst_valid_o, 1);
        rstn = 1'b0;
        #1;
        chk("rm_async_valid", inst_valid_o, 0);
        chk("rm_async_inst", inst_o, NOP);
        chk("rm_async_stall", fetch_stall_o, 1);
        @(posedge clk);
        #2 rstn = 1'b1;
        step(HOLD_NONE, 0, 0, 0, 1, 32'h0000_1234);
        step(HOLD_NONE, 0, 0, 0, 0, 0);
        chk("rm_late_rvalid", inst_valid_o, 0);
        chk("rm_req", ibus_req_o, 1);
        chk("rm_addr", ibus_addr_o, 32'h0);
    endtask

    // Transaction-level reference: expected PC stream, FIFO as a queue of
    // {addr,data}, one flag for "the outstanding fetch is stale".
    task automatic random_phase(input int ncyc);
        logic [63:0] mq[$];
        logic [31:0] m_pc, txn_addr, prev_addr, ja, rd, addr_now;
        logic        inflight, dirty, prev_req, prev_gnt, exp_vld, exp_req;
        logic        slv_wait, j, g, rv, req_now;
        logic [2:0]  h;
        int          slv_dly, qsz;
        m_pc = 32'h0; txn_addr = 32'h0; prev_addr = 32'h0;
        inflight = 0; dirty = 0; prev_req = 0; prev_gnt = 0;
        exp_vld = 1; exp_req = 0; slv_wait = 0; slv_dly = 0;
        reset_dut();
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            req_now  = ibus_req_o;
            addr_now = ibus_addr_o;
            qsz      = mq.size();
            if (exp_vld) chk("rnd_issue", req_now, exp_req);
            chk("rnd_valid", inst_valid_o, qsz != 0);
            if (qsz != 0) begin
                chk("rnd_inst", inst_o, mq[0][31:0]);
                chk("rnd_iaddr", inst_addr_o, mq[0][63:32]);
            end else begin
                chk("rnd_inst_nop", inst_o, NOP);
                chk("rnd_iaddr_zero", inst_addr_o, 32'h0);
            end
            if (req_now && !prev_req) begin
                chk("rnd_req_addr", addr_now, m_pc);
                txn_addr = m_pc;
                inflight = 1;
                dirty    = 0;
            end
            if (req_now && prev_req && !prev_gnt) chk("rnd_req_stable", addr_now, prev_addr);

            h  = ($urandom_range(0, 9) < 6) ? HOLD_NONE : 3'($urandom_range(1, 3));
            j  = ($urandom_range(0, 11) == 0);
            ja = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
            g  = req_now && ($urandom_range(0, 1) == 1);
            rv = slv_wait && (slv_dly == 0);
            rd = $urandom;
            drv(h, j, ja, g, rv, rd);
            #1;
            chk("rnd_stall", fetch_stall_o, (qsz == 0) && !j);

            exp_vld = !inflight || g || rv;
            exp_req = !inflight && (h == HOLD_NONE) && (qsz < 2) && !j;

            if (g) begin
                if (!(dirty || j)) m_pc = m_pc + 32'd4;
                slv_wait = 1;
                slv_dly  = $urandom_range(0, 2);
            end else if (slv_wait && !rv) begin
                slv_dly--;
            end
            if ((qsz != 0) && (h < HOLD_IF) && !j) void'(mq.pop_front());
            if (rv) begin
                if (!dirty && !j) mq.push_back({txn_addr, rd});
                inflight = 0;
                dirty    = 0;
                slv_wait = 0;
            end
            if (j) begin
                mq.delete();
                m_pc = {ja[31:2], 2'b00};
                if (inflight && !rv) dirty = 1;
            end
            prev_req  = req_now;
            prev_gnt  = g;
            prev_addr = addr_now;
        end
    endtask

    initial begin
        drv(HOLD_NONE, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        run_table();
        seq_jump_wait();
        seq_jump_req();
        seq_wrap();
        seq_reset_mid();
        random_phase(4000);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
